// File: rtl/zeroheti_pkg.sv
// Shared types for the APB peripheral hub: address rules, default 4-port map
// and the hub transaction state encoding.
package zeroheti_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } apb_rule_t;

  // Four contiguous 4 KiB windows starting at 0; the last bound is exclusive.
  localparam apb_rule_t [3:0] DefaultApbRules = {
    apb_rule_t'{base: 32'h0000_3000, last: 32'h0000_4000},
    apb_rule_t'{base: 32'h0000_2000, last: 32'h0000_3000},
    apb_rule_t'{base: 32'h0000_1000, last: 32'h0000_2000},
    apb_rule_t'{base: 32'h0000_0000, last: 32'h0000_1000}
  };

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR,
    RESP
  } hub_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: matches base <= addr < last against each rule,
// lowest rule index wins when rules overlap.
module apb_addr_decode
  import zeroheti_pkg::*;
#(
  parameter int unsigned NrPorts = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdxWidth = 2,
  parameter apb_rule_t [NrPorts-1:0] AddrRules = DefaultApbRules
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 hit_o,
  output logic [IdxWidth-1:0]  idx_o
);

  logic [63:0] addr_ext;
  assign addr_ext = 64'(addr_i);

  // Scanning from the top index down lets the lowest matching index overwrite last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NrPorts - 1; i >= 0; i--) begin
      if ((addr_ext >= 64'(AddrRules[i].base)) && (addr_ext < 64'(AddrRules[i].last))) begin
        hit_o = 1'b1;
        idx_o = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/apb_periph_hub.sv
// APB 1-to-N peripheral hub with registered decode and decode-error response.
// Define APB_HUB_TIMEOUT_EN to force an error response after TimeoutCycles ACCESS waits.
module apb_periph_hub
  import zeroheti_pkg::*;
#(
  parameter int unsigned NrPorts = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned TimeoutCycles = 255,
  parameter apb_rule_t [NrPorts-1:0] AddrRules = DefaultApbRules
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               mgr_psel_i,
  input  logic                               mgr_penable_i,
  input  logic                               mgr_pwrite_i,
  input  logic [AddrWidth-1:0]               mgr_paddr_i,
  input  logic [DataWidth-1:0]               mgr_pwdata_i,
  output logic [DataWidth-1:0]               mgr_prdata_o,
  output logic                               mgr_pready_o,
  output logic                               mgr_pslverr_o,
  output logic [NrPorts-1:0]                 sub_psel_o,
  output logic                               sub_penable_o,
  output logic                               sub_pwrite_o,
  output logic [AddrWidth-1:0]               sub_paddr_o,
  output logic [DataWidth-1:0]               sub_pwdata_o,
  input  logic [NrPorts-1:0][DataWidth-1:0]  sub_prdata_i,
  input  logic [NrPorts-1:0]                 sub_pready_i,
  input  logic [NrPorts-1:0]                 sub_pslverr_i,
  output logic                               err_irq_o
);

  localparam int unsigned IdxWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  // Handshake: a request is taken when mgr_psel_i is high in IDLE; the manager
  // sees exactly one mgr_pready_o cycle (RESP) per accepted request.
  hub_state_e            state_q;
  logic [IdxWidth-1:0]   idx_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [DataWidth-1:0]  wdata_q;
  logic [DataWidth-1:0]  rdata_q;
  logic                  write_q;
  logic                  slverr_q;
  logic                  penable_q;
  logic                  pready_q;
  logic                  irq_q;
  logic [NrPorts-1:0]    psel_q;

  logic                  dec_hit;
  logic [IdxWidth-1:0]   dec_idx;
  logic [NrPorts-1:0]    dec_onehot;

`ifdef APB_HUB_TIMEOUT_EN
  logic [15:0]           cnt_q;
`else
  logic [15:0]           unused_timeout;
  assign unused_timeout = 16'(TimeoutCycles);
`endif

  // The manager's penable phase carries no information the hub needs.
  logic unused_penable;
  assign unused_penable = mgr_penable_i;

  apb_addr_decode #(
    .NrPorts   (NrPorts),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth),
    .AddrRules (AddrRules)
  ) u_decode (
    .addr_i (mgr_paddr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  always_comb begin
    dec_onehot = '0;
    dec_onehot[dec_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      slverr_q  <= 1'b0;
      penable_q <= 1'b0;
      pready_q  <= 1'b0;
      irq_q     <= 1'b0;
      psel_q    <= '0;
`ifdef APB_HUB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      pready_q <= 1'b0;
      irq_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mgr_psel_i) begin
            addr_q  <= mgr_paddr_i;
            wdata_q <= mgr_pwdata_i;
            write_q <= mgr_pwrite_i;
            if (dec_hit) begin
              idx_q   <= dec_idx;
              psel_q  <= dec_onehot;
              state_q <= SETUP;
`ifdef APB_HUB_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q <= DECERR;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (sub_pready_i[idx_q]) begin
            rdata_q   <= sub_prdata_i[idx_q];
            slverr_q  <= sub_pslverr_i[idx_q];
            psel_q    <= '0;
            penable_q <= 1'b0;
            pready_q  <= 1'b1;
            state_q   <= RESP;
          end
`ifdef APB_HUB_TIMEOUT_EN
          // A ready arriving on the limit cycle still completes normally.
          else if (cnt_q == 16'(TimeoutCycles - 1)) begin
            rdata_q   <= '0;
            slverr_q  <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pready_q  <= 1'b1;
            irq_q     <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        DECERR: begin
          rdata_q  <= '0;
          slverr_q <= 1'b1;
          pready_q <= 1'b1;
          irq_q    <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          rdata_q  <= '0;
          slverr_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mgr_prdata_o  = rdata_q;
  assign mgr_pready_o  = pready_q;
  assign mgr_pslverr_o = slverr_q;
  assign sub_psel_o    = psel_q;
  assign sub_penable_o = penable_q;
  assign sub_pwrite_o  = write_q;
  assign sub_paddr_o   = addr_q;
  assign sub_pwdata_o  = wdata_q;
  assign err_irq_o     = irq_q;

endmodule

// File: tb/tb_apb_periph_hub.sv
// Directed bench for apb_periph_hub: a transaction-level model expands each
// request into the expected per-cycle output trace, checked every cycle.
module tb_apb_periph_hub;
  import zeroheti_pkg::*;

  localparam int NP = 4;
  localparam int TO = 8;

  // Rule 1 overlaps rule 0 on [0x0C00, 0x1000) so the priority rule is visible.
  localparam apb_rule_t [NP-1:0] TB_RULES = {
    apb_rule_t'{base: 32'h0000_3000, last: 32'h0000_4000},
    apb_rule_t'{base: 32'h0000_2000, last: 32'h0000_3000},
    apb_rule_t'{base: 32'h0000_0C00, last: 32'h0000_2000},
    apb_rule_t'{base: 32'h0000_0000, last: 32'h0000_1000}
  };

  typedef struct packed {
    logic [3:0]  psel;
    logic        pen;
    logic        rdy;
    logic [31:0] rdata;
    logic        err;
    logic        irq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } exp_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   mgr_psel_i, mgr_penable_i, mgr_pwrite_i;
  logic [31:0]            mgr_paddr_i, mgr_pwdata_i;
  logic [31:0]            mgr_prdata_o;
  logic                   mgr_pready_o, mgr_pslverr_o;
  logic [NP-1:0]          sub_psel_o;
  logic                   sub_penable_o, sub_pwrite_o;
  logic [31:0]            sub_paddr_o, sub_pwdata_o;
  logic [NP-1:0][31:0]    sub_prdata_i;
  logic [NP-1:0]          sub_pready_i, sub_pslverr_i;
  logic                   err_irq_o;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc, rdy_cyc, irq_cnt, acc_cnt, lat;
  logic [31:0] last_rdata;
  logic        last_err;
  int          cur_waits;
  logic [31:0] cur_rdata;
  logic        cur_slverr;

  apb_periph_hub #(
    .NrPorts       (NP),
    .AddrWidth     (32),
    .DataWidth     (32),
    .TimeoutCycles (TO),
    .AddrRules     (TB_RULES)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mgr_psel_i    (mgr_psel_i),
    .mgr_penable_i (mgr_penable_i),
    .mgr_pwrite_i  (mgr_pwrite_i),
    .mgr_paddr_i   (mgr_paddr_i),
    .mgr_pwdata_i  (mgr_pwdata_i),
    .mgr_prdata_o  (mgr_prdata_o),
    .mgr_pready_o  (mgr_pready_o),
    .mgr_pslverr_o (mgr_pslverr_o),
    .sub_psel_o    (sub_psel_o),
    .sub_penable_o (sub_penable_o),
    .sub_pwrite_o  (sub_pwrite_o),
    .sub_paddr_o   (sub_paddr_o),
    .sub_pwdata_o  (sub_pwdata_o),
    .sub_prdata_i  (sub_prdata_i),
    .sub_pready_i  (sub_pready_i),
    .sub_pslverr_i (sub_pslverr_i),
    .err_irq_o     (err_irq_o)
  );

  // Clock and cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode: first rule (lowest index) containing the address, else -1.
  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if (a >= TB_RULES[i].base && a < TB_RULES[i].last) return i;
    return -1;
  endfunction

  // Peripheral models: selected port answers after cur_waits ACCESS cycles
  // (never if negative); unselected ports present ready with junk data.
  always @(negedge clk_i) begin
    for (int p = 0; p < NP; p++) begin
      if (sub_psel_o[p]) begin
        sub_prdata_i[p]  = cur_rdata;
        sub_pslverr_i[p] = cur_slverr;
        if (sub_penable_o) begin
          sub_pready_i[p] = (cur_waits >= 0) && (acc_cnt == cur_waits);
          acc_cnt++;
        end else begin
          sub_pready_i[p] = 1'b0;
          acc_cnt = 0;
        end
      end else begin
        sub_pready_i[p]  = 1'b1;
        sub_prdata_i[p]  = 32'hDEAD_0000 | 32'(p);
        sub_pslverr_i[p] = 1'b1;
      end
    end
  end

  // Scoreboard: one expected entry per cycle of an active transaction.
  always @(negedge clk_i) begin
    exp_t e;
    if (mgr_pready_o) begin
      rdy_cyc    = cyc;
      last_rdata = mgr_prdata_o;
      last_err   = mgr_pslverr_o;
    end
    if (err_irq_o) irq_cnt++;
    if (!rst_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sub_psel", 64'(sub_psel_o), 64'(e.psel));
      chk("sub_penable", 64'(sub_penable_o), 64'(e.pen));
      chk("mgr_pready", 64'(mgr_pready_o), 64'(e.rdy));
      chk("mgr_prdata", 64'(mgr_prdata_o), 64'(e.rdata));
      chk("mgr_pslverr", 64'(mgr_pslverr_o), 64'(e.err));
      chk("err_irq", 64'(err_irq_o), 64'(e.irq));
      if (e.psel != 4'd0) begin
        chk("sub_paddr", 64'(sub_paddr_o), 64'(e.addr));
        chk("sub_pwdata", 64'(sub_pwdata_o), 64'(e.wdata));
        chk("sub_pwrite", 64'(sub_pwrite_o), 64'(e.wr));
      end
    end
  end

  // Driver: call at posedge+1 with the hub idle; returns after the RESP cycle.
  task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic slverr);
    int   port, n_acc, n;
    exp_t e;
    port = model_decode(addr);
    cur_waits = waits; cur_rdata = rdata; cur_slverr = slverr;
    rdy_cyc = -1; irq_cnt = 0; last_rdata = '0; last_err = 1'b0;
    mgr_psel_i = 1'b1; mgr_penable_i = 1'b0;
    mgr_paddr_i = addr; mgr_pwdata_i = wdata; mgr_pwrite_i = wr;
    start_cyc = cyc;
    e = '0; e.addr = addr; e.wdata = wdata; e.wr = wr;
    exp_q.push_back(e);
    if (port >= 0) begin
      e.psel = 4'(1 << port);
      exp_q.push_back(e);
      n_acc = (waits < 0) ? TO : waits + 1;
      e.pen = 1'b1;
      for (int k = 0; k < n_acc; k++) exp_q.push_back(e);
      e.psel = '0; e.pen = 1'b0; e.rdy = 1'b1;
      if (waits < 0) begin
        e.rdata = '0; e.err = 1'b1; e.irq = 1'b1;
      end else begin
        e.rdata = rdata; e.err = slverr;
      end
      exp_q.push_back(e);
    end else begin
      exp_q.push_back(e);
      e.rdy = 1'b1; e.err = 1'b1; e.irq = 1'b1;
      exp_q.push_back(e);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i); #1;
      if (k == 0) begin
        // Manager changes after acceptance must not leak to the peripheral bus.
        mgr_penable_i = 1'b1;
        mgr_paddr_i = ~addr; mgr_pwdata_i = ~wdata; mgr_pwrite_i = ~wr;
      end
    end
    mgr_psel_i = 1'b0; mgr_penable_i = 1'b0;
    lat = (rdy_cyc < 0) ? -1 : rdy_cyc - start_cyc + 1;
  endtask

  logic [31:0] bnd_addr [5] = '{32'h0000_1FFC, 32'h0000_2000, 32'h0000_4000, 32'h0000_0000, 32'h0000_0BFC};
  int          bnd_port [5] = '{1, 2, -1, 0, 0};

  initial begin
    rst_i = 1'b1;
    mgr_psel_i = 1'b0; mgr_penable_i = 1'b0; mgr_pwrite_i = 1'b0;
    mgr_paddr_i = '0; mgr_pwdata_i = '0;
    cur_waits = 0; cur_rdata = '0; cur_slverr = 1'b0; acc_cnt = 0;
    rdy_cyc = -1; irq_cnt = 0; last_rdata = '0; last_err = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_psel", 64'(sub_psel_o), 64'd0);
    chk("rst_penable", 64'(sub_penable_o), 64'd0);
    chk("rst_pready", 64'(mgr_pready_o), 64'd0);
    chk("rst_prdata", 64'(mgr_prdata_o), 64'd0);
    chk("rst_pslverr", 64'(mgr_pslverr_o), 64'd0);
    chk("rst_irq", 64'(err_irq_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Zero-wait write to port-1 base
    do_txn(32'h0000_1000, 1'b1, 32'hA5A5_0001, 0, 32'h0, 1'b0);
    chk("t1_latency", 64'(lat), 64'd4);
    chk("t1_pslverr", 64'(last_err), 64'd0);
    chk("t1_irq_cnt", 64'(irq_cnt), 64'd0);

    // Read port 2 with 3 wait states
    do_txn(32'h0000_2010, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0);
    chk("t2_latency", 64'(lat), 64'd7);
    chk("t2_prdata", 64'(last_rdata), 64'h1234_5678);
    chk("t2_pslverr", 64'(last_err), 64'd0);

    // Unmapped address
    do_txn(32'h0000_5000, 1'b0, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
    chk("t3_latency", 64'(lat), 64'd3);
    chk("t3_prdata", 64'(last_rdata), 64'd0);
    chk("t3_pslverr", 64'(last_err), 64'd1);
    chk("t3_irq_cnt", 64'(irq_cnt), 64'd1);

    // Overlapping rules 0 and 1: rule 0 must win
    chk("model_dec_0c04", 64'(model_decode(32'h0000_0C04)), 64'd0);
    do_txn(32'h0000_0C04, 1'b0, 32'h0, 1, 32'hC0FF_EE00, 1'b0);
    chk("t4_latency", 64'(lat), 64'd5);
    chk("t4_prdata", 64'(last_rdata), 64'hC0FF_EE00);

    // Peripheral error passes through without an interrupt
    do_txn(32'h0000_3FFC, 1'b1, 32'h5A5A_5A5A, 2, 32'h0000_0042, 1'b1);
    chk("t5_pslverr", 64'(last_err), 64'd1);
    chk("t5_irq_cnt", 64'(irq_cnt), 64'd0);
    chk("t5_latency", 64'(lat), 64'd6);

    // Window boundaries, back to back
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("model_dec_bnd%0d", i), 64'(model_decode(bnd_addr[i])), 64'(bnd_port[i]));
      do_txn(bnd_addr[i], i[0], 32'h1111_0000 + 32'(i), i % 3, 32'hB000_0000 + 32'(i), 1'b0);
      chk($sformatf("bnd%0d_latency", i), 64'(lat), (bnd_port[i] < 0) ? 64'd3 : 64'(4 + i % 3));
    end

    // Reset while waiting in ACCESS
    cur_waits = -1;
    mgr_psel_i = 1'b1; mgr_penable_i = 1'b0; mgr_pwrite_i = 1'b0;
    mgr_paddr_i = 32'h0000_3000; mgr_pwdata_i = 32'h0;
    @(posedge clk_i); #1;
    mgr_penable_i = 1'b1;
    @(posedge clk_i); #3;
    chk("midrst_pre_psel", 64'(sub_psel_o), 64'b1000);
    chk("midrst_pre_penable", 64'(sub_penable_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_psel", 64'(sub_psel_o), 64'd0);
    chk("midrst_penable", 64'(sub_penable_o), 64'd0);
    chk("midrst_pready", 64'(mgr_pready_o), 64'd0);
    chk("midrst_irq", 64'(err_irq_o), 64'd0);
    mgr_psel_i = 1'b0; mgr_penable_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("postrst_pready", 64'(mgr_pready_o), 64'd0);
    chk("postrst_psel", 64'(sub_psel_o), 64'd0);
    @(posedge clk_i); #1;
    do_txn(32'h0000_2004, 1'b1, 32'hCAFE_0002, 0, 32'h0, 1'b0);
    chk("postrst_latency", 64'(lat), 64'd4);

`ifdef APB_HUB_TIMEOUT_EN
    // Peripheral never ready: forced error after TO ACCESS cycles
    do_txn(32'h0000_1004, 1'b0, 32'h0, -1, 32'h0000_0077, 1'b0);
    chk("to_latency", 64'(lat), 64'd11);
    chk("to_pslverr", 64'(last_err), 64'd1);
    chk("to_prdata", 64'(last_rdata), 64'd0);
    chk("to_irq_cnt", 64'(irq_cnt), 64'd1);
`endif

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
